vga_ctrl: RTL and testbench

Parametrised VGA controller that generalises the current single-bit, fixed 640x480 VGA top level.
- Generates its own pixel tick and H/V timing from parameters, all of them set at elaboration.
- Presents pixel coordinates to an external pixel source with a configurable return latency.
- Delays sync and blank to line up with the returned colour, and expands N-bit colour to the 8-bit DAC channels.
- Sits between the graphics/robot-rendering logic and the board VGA pins.

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/vga_timing.sv | 113 +++++++++++
 rtl/vga_ctrl.sv | 128 ++++++++++++
 tb/tb_vga_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA controller:
//   - vga_axis_t / vga_timing_t : per-axis timing (active, front porch, sync,
//                                 back porch) and the H/V pair.
//   - VGA_640X480_60            : default 640x480@60 timing.
//   - vga_ctl_t                 : the control bits carried through the delay
//                                 line (sync and active flags).
//   - axis_total()              : total count of one axis.
//   - expand_color()            : MSB-first replication of an N-bit channel
//                                 to 8 bits.
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_SYNC_POL   = 0;
    localparam int DEF_COLOR_BITS = 1;
    localparam int DEF_PIX_LAT    = 1;
    localparam int DEF_CNT_W      = 10;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } vga_ctl_t;

    function automatic int axis_total(input vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    // Replicates value[bits-1:0] MSB-first until 8 bits are filled,
    // e.g. bits=3, value=101 -> 101_101_10.
    function automatic logic [7:0] expand_color(input logic [7:0] value, input int bits);
        logic [7:0] res;
        logic [2:0] src;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            src = 3'(bits - 1 - (i % bits));
            res[3'(7 - i)] = value[src];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Pixel-clock divider, horizontal/vertical counters and raw sync/active
// decode.
//   clk, srst        : clock and synchronous active-high reset
//   pix_tick_o       : one-clock pulse on the last clk of every pixel period
//   pix_x_o/pix_y_o  : current h/v counter values
//   pix_active_o     : counters inside the visible area
//   hs_raw_o/vs_raw_o: undelayed sync, high while inside the sync interval
//   line_start_o     : pix_tick and h==0
//   frame_start_o    : pix_tick and h==0 and v==0
// -----------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = VGA_640X480_60.h.active,
    parameter int H_FP     = VGA_640X480_60.h.fp,
    parameter int H_SYNC   = VGA_640X480_60.h.sync,
    parameter int H_BP     = VGA_640X480_60.h.bp,
    parameter int V_ACTIVE = VGA_640X480_60.v.active,
    parameter int V_FP     = VGA_640X480_60.v.fp,
    parameter int V_SYNC   = VGA_640X480_60.v.sync,
    parameter int V_BP     = VGA_640X480_60.v.bp,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             srst,
    output logic             pix_tick_o,
    output logic [CNT_W-1:0] pix_x_o,
    output logic [CNT_W-1:0] pix_y_o,
    output logic             pix_active_o,
    output logic             hs_raw_o,
    output logic             vs_raw_o,
    output logic             line_start_o,
    output logic             frame_start_o
);

    localparam vga_timing_t TIM = '{
        h: '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
        v: '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP}
    };
    localparam int H_TOTAL = axis_total(TIM.h);
    localparam int V_TOTAL = axis_total(TIM.v);

    if (CLK_DIV < 1 || H_SYNC < 1 || V_SYNC < 1 ||
        H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cfg
        $error("vga_timing: timing does not fit the counter width or is malformed");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    // Decode comparisons are one bit wider so an axis that fills the whole
    // counter range cannot alias its end bound to zero.
    localparam int CW1 = CNT_W + 1;
    localparam logic [CW1-1:0] H_ACT_END  = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] V_ACT_END  = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0] HS_FIRST   = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW1-1:0] HS_LAST    = CW1'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW1-1:0] VS_FIRST   = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW1-1:0] VS_LAST    = CW1'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [CW1-1:0]   h_ext, v_ext;
    logic             tick;

    // With CLK_DIV=1 the divider never leaves 0, so tick is permanently high.
    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign h_ext = {1'b0, h_q};
    assign v_ext = {1'b0, v_q};

    assign pix_tick_o    = tick;
    assign pix_x_o       = h_q;
    assign pix_y_o       = v_q;
    assign pix_active_o  = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign hs_raw_o      = (h_ext >= HS_FIRST) && (h_ext <= HS_LAST);
    assign vs_raw_o      = (v_ext >= VS_FIRST) && (v_ext <= VS_LAST);
    assign line_start_o  = tick && (h_q == '0);
    assign frame_start_o = tick && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_ctrl.sv
// -----------------------------------------------------------------------------
// vga_ctrl
// Parametrised VGA controller. Presents pixel coordinates to an external
// pixel source, delays sync/active by PIX_LAT pixel periods so they line up
// with the returned colour, masks and expands colour to 8-bit DAC channels.
//   clock_50, reset_key       : clock and synchronous active-high reset
//   pix_tick                  : last clock_50 of each pixel period
//   pix_x, pix_y, pix_active  : coordinate presented to the pixel source
//   pix_rgb                   : {r,g,b} returned by the source, PIX_LAT-1
//                               ticks after the coordinate
//   line_start, frame_start   : combinational start-of-line/frame strobes
//   vga_hs, vga_vs            : delayed sync at the SYNC_POL active level
//   vga_blank_n               : delayed active flag
//   vga_r, vga_g, vga_b       : 8-bit DAC values, zero outside active area
// -----------------------------------------------------------------------------
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = VGA_640X480_60.h.active,
    parameter int H_FP       = VGA_640X480_60.h.fp,
    parameter int H_SYNC     = VGA_640X480_60.h.sync,
    parameter int H_BP       = VGA_640X480_60.h.bp,
    parameter int V_ACTIVE   = VGA_640X480_60.v.active,
    parameter int V_FP       = VGA_640X480_60.v.fp,
    parameter int V_SYNC     = VGA_640X480_60.v.sync,
    parameter int V_BP       = VGA_640X480_60.v.bp,
    parameter int SYNC_POL   = DEF_SYNC_POL,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int PIX_LAT    = DEF_PIX_LAT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clock_50,
    input  logic                    reset_key,
    output logic                    pix_tick,
    output logic [CNT_W-1:0]        pix_x,
    output logic [CNT_W-1:0]        pix_y,
    output logic                    pix_active,
    input  logic [3*COLOR_BITS-1:0] pix_rgb,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_blank_n,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b
);

    if (COLOR_BITS < 1 || COLOR_BITS > 8 || PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_cfg
        $error("vga_ctrl: COLOR_BITS must be 1..8 and PIX_LAT 1..4");
    end

    localparam logic SYNC_LVL = (SYNC_POL != 0);

    logic hs_raw;
    logic vs_raw;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk           (clock_50),
        .srst          (reset_key),
        .pix_tick_o    (pix_tick),
        .pix_x_o       (pix_x),
        .pix_y_o       (pix_y),
        .pix_active_o  (pix_active),
        .hs_raw_o      (hs_raw),
        .vs_raw_o      (vs_raw),
        .line_start_o  (line_start),
        .frame_start_o (frame_start)
    );

    vga_ctl_t                 raw_ctl;
    vga_ctl_t [PIX_LAT-1:0]   stage_q, stage_d;
    // chain[k] is the input of stage k; chain[PIX_LAT-1] therefore describes
    // the coordinate whose colour is on pix_rgb right now.
    vga_ctl_t [PIX_LAT:0]     chain;
    logic     [2:0][7:0]      chan_exp;
    logic     [2:0][7:0]      rgb_q, rgb_d;

    assign raw_ctl = '{hs: hs_raw, vs: vs_raw, active: pix_active};
    assign chain   = {stage_q, raw_ctl};

    // Channel 0 is blue (LSBs of pix_rgb), channel 2 is red.
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_chan
        assign chan_exp[gi] = expand_color(8'(pix_rgb[gi*COLOR_BITS +: COLOR_BITS]), COLOR_BITS);
    end

    always_comb begin
        stage_d = stage_q;
        rgb_d   = rgb_q;
        if (pix_tick) begin
            stage_d = chain[PIX_LAT-1:0];
            rgb_d   = chain[PIX_LAT-1].active ? chan_exp : '0;
        end
    end

    // Reset clears the whole delay line so nothing from before the reset
    // can reach the pins afterwards.
    always_ff @(posedge clock_50) begin
        if (reset_key) begin
            stage_q <= '0;
            rgb_q   <= '0;
        end else begin
            stage_q <= stage_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga_hs      = stage_q[PIX_LAT-1].hs ~^ SYNC_LVL;
    assign vga_vs      = stage_q[PIX_LAT-1].vs ~^ SYNC_LVL;
    assign vga_blank_n = stage_q[PIX_LAT-1].active;
    assign vga_r       = rgb_q[2];
    assign vga_g       = rgb_q[1];
    assign vga_b       = rgb_q[0];

endmodule

// File: tb/tb_vga_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_ctrl
// dut : reduced timing H 8/2/2/2, V 4/1/1/1 (14 x 7), CLK_DIV=2, PIX_LAT=3,
//       COLOR_BITS=3, active-low sync, two-tick registered pixel source.
// dut2: same timing, CLK_DIV=1, PIX_LAT=1, COLOR_BITS=1, active-high sync,
//       constant pix_rgb=101.
// -----------------------------------------------------------------------------
module tb_vga_ctrl;

    localparam int PIX_LAT = 3;
    localparam int CNT_W   = 6;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } sb_t;

    localparam sb_t IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};

    logic clock_50  = 1'b0;
    logic reset_key = 1'b1;
    always #5 clock_50 = ~clock_50;

    logic             pix_tick, pix_active, line_start, frame_start;
    logic [CNT_W-1:0] pix_x, pix_y;
    logic [8:0]       pix_rgb;
    logic             vga_hs, vga_vs, vga_blank_n;
    logic [7:0]       vga_r, vga_g, vga_b;

    logic             pix_tick2, pix_active2, line_start2, frame_start2;
    logic [CNT_W-1:0] pix_x2, pix_y2;
    logic [2:0]       pix_rgb2;
    logic             vga_hs2, vga_vs2, vga_blank_n2;
    logic [7:0]       vga_r2, vga_g2, vga_b2;

    int total = 0;
    int bad   = 0;

    vga_ctrl #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .COLOR_BITS(3), .PIX_LAT(PIX_LAT), .CNT_W(CNT_W)
    ) dut (
        .clock_50(clock_50), .reset_key(reset_key), .pix_tick(pix_tick),
        .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active), .pix_rgb(pix_rgb),
        .line_start(line_start), .frame_start(frame_start), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b)
    );

    vga_ctrl #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .COLOR_BITS(1), .PIX_LAT(1), .CNT_W(CNT_W)
    ) dut2 (
        .clock_50(clock_50), .reset_key(reset_key), .pix_tick(pix_tick2),
        .pix_x(pix_x2), .pix_y(pix_y2), .pix_active(pix_active2), .pix_rgb(pix_rgb2),
        .line_start(line_start2), .frame_start(frame_start2), .vga_hs(vga_hs2),
        .vga_vs(vga_vs2), .vga_blank_n(vga_blank_n2), .vga_r(vga_r2), .vga_g(vga_g2),
        .vga_b(vga_b2)
    );

    assign pix_rgb2 = 3'b101;

    // Pixel source for dut: colour depends on x parity, returned two ticks
    // after the coordinate (PIX_LAT-1).
    logic [8:0] src1_q, src2_q;
    always @(posedge clock_50) begin
        if (pix_tick) begin
            src1_q <= pix_x[0] ? 9'b101_011_000 : 9'b010_100_111;
            src2_q <= src1_q;
        end
    end
    assign pix_rgb = src2_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pin values for coordinate (x,y) of dut, hand-derived:
    // hs for x in 10..11, vs for y==5, active x<8 && y<4.
    // Odd x: 101,011,000 -> B6,6D,00. Even x: 010,100,111 -> 49,92,FF.
    function automatic sb_t model(input int x, input int y);
        sb_t e;
        e.hs    = !(x >= 10 && x <= 11);
        e.vs    = (y != 5);
        e.blank = (x < 8) && (y < 4);
        if (!e.blank)       {e.r, e.g, e.b} = 24'h000000;
        else if (x % 2 == 1) {e.r, e.g, e.b} = 24'hB66D00;
        else                 {e.r, e.g, e.b} = 24'h4992FF;
        return e;
    endfunction

    // Scoreboard: each presented coordinate pushes its expected pin values;
    // reset flushes and preloads the idle periods of the cleared delay line.
    sb_t sb_q[$];
    int  pops      = 0;
    bit  tick_seen = 1'b0;

    always @(negedge clock_50) begin
        if (reset_key) begin
            sb_q.delete();
            for (int i = 0; i < PIX_LAT - 1; i++) sb_q.push_back(IDLE);
        end else if (pix_tick) begin
            sb_q.push_back(model(int'(pix_x), int'(pix_y)));
        end
    end

    // Monitor: the pins change on the clock after a tick; check right then.
    always @(negedge clock_50) begin
        sb_t e;
        #1;
        if (!reset_key && tick_seen) begin
            if (sb_q.size() >= PIX_LAT) begin
                e = sb_q.pop_front();
                pops++;
                chk("sb_hs", vga_hs, e.hs);
                chk("sb_vs", vga_vs, e.vs);
                chk("sb_blank_n", vga_blank_n, e.blank);
                chk("sb_r", vga_r, e.r);
                chk("sb_g", vga_g, e.g);
                chk("sb_b", vga_b, e.b);
            end else begin
                chk("sb_depth", sb_q.size(), PIX_LAT);
            end
        end
        tick_seen = pix_tick && !reset_key;
    end

    task automatic wait2(input int x, input int y, input string nm);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock_50);
            if (int'(pix_x2) == x && int'(pix_y2) == y) begin
                found = 1'b1;
                break;
            end
        end
        chk(nm, found, 1'b1);
    endtask

    initial begin
        int  ticks, hs_lo, vs_lo, bl_hi, ls_cnt, prev_x, prev_y, cnt;
        bit  got;

        reset_key = 1'b1;
        repeat (3) @(posedge clock_50);
        #1 reset_key = 1'b0;

        // Reset state (last posedge still had reset applied).
        @(negedge clock_50);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_hs", vga_hs, 1'b1);
        chk("rst_vs", vga_vs, 1'b1);
        chk("rst_blank_n", vga_blank_n, 1'b0);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        chk("rst_tick", pix_tick, 1'b0);
        chk("rst_line_start", line_start, 1'b0);
        $display("reset state checked");

        // First tick one clock after reset, with line and frame start.
        @(negedge clock_50);
        chk("first_tick", pix_tick, 1'b1);
        chk("first_frame_start", frame_start, 1'b1);
        chk("first_line_start", line_start, 1'b1);

        // One frame: ticks until the next frame_start, sync/blank counts
        // and counter wrap behaviour.
        ticks = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0; ls_cnt = 0; got = 1'b0;
        prev_x = 0; prev_y = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clock_50);
            if (pix_tick) begin
                ticks++;
                if (!vga_hs)     hs_lo++;
                if (!vga_vs)     vs_lo++;
                if (vga_blank_n) bl_hi++;
                if (line_start)  ls_cnt++;
                if (prev_x == 13) begin
                    chk("h_wrap", pix_x, 0);
                    chk("v_incr", pix_y, (prev_y + 1) % 7);
                end
                prev_x = int'(pix_x);
                prev_y = int'(pix_y);
                if (frame_start) got = 1'b1;
            end
        end
        chk("frame_found", got, 1'b1);
        chk("ticks_per_frame", ticks, 98);
        chk("hs_low_ticks", hs_lo, 14);
        chk("vs_low_ticks", vs_lo, 14);
        chk("blank_high_ticks", bl_hi, 32);
        chk("line_starts", ls_cnt, 7);
        $display("frame timing checked: ticks=%0d", ticks);

        // Mid-frame reset at h=5, v=2.
        got = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock_50);
            if (int'(pix_x) == 5 && int'(pix_y) == 2 && !pix_tick) begin
                got = 1'b1;
                break;
            end
        end
        chk("midreset_found", got, 1'b1);
        @(posedge clock_50);
        #1 reset_key = 1'b1;
        @(posedge clock_50);
        #1 reset_key = 1'b0;
        @(negedge clock_50);
        chk("mr_pix_x", pix_x, 0);
        chk("mr_pix_y", pix_y, 0);
        chk("mr_hs", vga_hs, 1'b1);
        chk("mr_vs", vga_vs, 1'b1);
        chk("mr_blank_n", vga_blank_n, 1'b0);
        chk("mr_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        chk("d2_rst_with_tick_x", pix_x2, 0);
        chk("d2_rst_with_tick_y", pix_y2, 0);
        chk("d2_tick_in_rst_cycle", pix_tick2, 1'b1);
        @(negedge clock_50);
        chk("d2_x_after_rst", pix_x2, 1);
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (vga_blank_n) begin
                got = 1'b1;
                break;
            end
            if (pix_tick) cnt++;
            @(negedge clock_50);
        end
        chk("blank_rise_found", got, 1'b1);
        chk("blank_rise_ticks", cnt, PIX_LAT);
        $display("mid-frame reset checked: blank_n rose after %0d ticks", cnt);

        // dut2: tick every clock and counters advance every clock.
        prev_x = int'(pix_x2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock_50);
            chk("d2_tick_high", pix_tick2, 1'b1);
            chk("d2_x_step", pix_x2, (prev_x + 1) % 14);
            prev_x = int'(pix_x2);
        end

        // dut2 output polarity and 1-bit colour expansion (PIX_LAT=1: the
        // pins show the previous coordinate).
        wait2(11, 2, "d2_wait_hs_on");
        chk("d2_hs_active_high", vga_hs2, 1'b1);
        wait2(10, 3, "d2_wait_hs_off");
        chk("d2_hs_idle_low", vga_hs2, 1'b0);
        wait2(1, 5, "d2_wait_vs_on");
        chk("d2_vs_active_high", vga_vs2, 1'b1);
        wait2(1, 6, "d2_wait_vs_off");
        chk("d2_vs_idle_low", vga_vs2, 1'b0);
        wait2(3, 1, "d2_wait_active");
        chk("d2_rgb_active", {vga_r2, vga_g2, vga_b2}, 24'hFF00FF);
        chk("d2_blank_active", vga_blank_n2, 1'b1);
        wait2(10, 1, "d2_wait_porch");
        chk("d2_rgb_porch", {vga_r2, vga_g2, vga_b2}, 24'h000000);
        chk("d2_blank_porch", vga_blank_n2, 1'b0);
        $display("dut2 checks done");

        repeat (300) @(negedge clock_50);
        chk("sb_pops_enough", pops > 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
